// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud arithmetic
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  function automatic int calc_bit_cyc(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// AXI-Stream beat bundle carrying received UART bytes to the consumer.
interface uart_rx_axis_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master(output data, output valid, output last, input ready);
  modport slave (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 deserializer: line synchronizer, framing FSM and shift register.
// Emits single-cycle byte_ok / frame_err strobes at the stop-bit sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_byte,
  output logic             o_byte_ok,
  output logic             o_frame_err,
  output logic             o_idle,
  output logic             o_start
);

  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);
  localparam int BITN_W   = $clog2(WIDTH + 1);

  logic [1:0]        r_sync;
  uart_state_t       r_state;
  uart_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [BITN_W-1:0] r_bitn;
  logic [WIDTH-1:0]  r_shreg;
  logic              w_rx_s;
  logic              w_cnt_clr;
  logic              w_shift;
  logic              w_cnt_half;
  logic              w_cnt_full;

  assign w_rx_s     = r_sync[1];
  assign w_cnt_half = (r_cnt == CNT_W'(HALF_CYC - 1));
  assign w_cnt_full = (r_cnt == CNT_W'(BIT_CYC - 1));
  assign o_byte     = r_shreg;
  assign o_idle     = (r_state == ST_IDLE);
  assign o_start    = o_idle && !w_rx_s;

  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    o_byte_ok   = 1'b0;
    o_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_next    = ST_START;
          w_cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (w_cnt_half) begin
          w_cnt_clr = 1'b1;
          w_next    = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_cnt_full) begin
          w_shift   = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_bitn == BITN_W'(WIDTH - 1)) w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_cnt_full) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            o_byte_ok = 1'b1;
            w_next    = ST_IDLE;
          end else begin
            o_frame_err = 1'b1;
            w_next      = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx_s) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bit counter only runs while timing a bit; it rests at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_next;
      if (w_cnt_clr || r_state == ST_IDLE || r_state == ST_BREAK) r_cnt <= '0;
      else r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != ST_DATA) r_bitn <= '0;
      else if (w_shift) r_bitn <= r_bitn + BITN_W'(1);
      if (w_shift) r_shreg <= {w_rx_s, r_shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with AXI-Stream output: holds one byte back so that
// m_axis_last can be derived from line idle or a framing error.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  uart_rx_axis_if.master         m_axis,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int BIT_CYC  = calc_bit_cyc(CLK_RATE, BAUD);
  localparam int IDLE_LIM = IDLE_BITS * BIT_CYC;
  localparam int IDLE_W   = $clog2(IDLE_LIM + 1);

  logic [WIDTH-1:0]  w_byte;
  logic              w_byte_ok;
  logic              w_core_ferr;
  logic              w_idle;
  logic              w_start;
  logic              w_timeout;
  logic              w_rel;
  logic              w_rel_last;
  logic              w_out_free;
  logic [WIDTH-1:0]  r_hold;
  logic              r_hold_v;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_frame_err;
  logic              r_overrun;

  uart_rx_core #(
    .WIDTH  (WIDTH),
    .BIT_CYC(BIT_CYC)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (uart_rx),
    .o_byte     (w_byte),
    .o_byte_ok  (w_byte_ok),
    .o_frame_err(w_core_ferr),
    .o_idle     (w_idle),
    .o_start    (w_start)
  );

  assign m_axis.data  = r_data;
  assign m_axis.valid = r_valid;
  assign m_axis.last  = r_last;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;

  // A new start edge beats an idle timeout in the same cycle, keeping the hold.
  always_comb begin
    w_timeout  = w_idle && !w_start && r_hold_v && (r_idle_cnt == IDLE_W'(IDLE_LIM));
    w_rel      = 1'b0;
    w_rel_last = 1'b0;
    if (w_byte_ok && r_hold_v) begin
      w_rel = 1'b1;
    end else if ((w_core_ferr && r_hold_v) || w_timeout) begin
      w_rel      = 1'b1;
      w_rel_last = 1'b1;
    end
    w_out_free = !r_valid || m_axis.ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold     <= '0;
      r_hold_v   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (w_byte_ok) begin
        r_hold   <= w_byte;
        r_hold_v <= 1'b1;
      end else if (w_rel) begin
        r_hold_v <= 1'b0;
      end
      if (!w_idle || w_start || w_rel) r_idle_cnt <= '0;
      else if (r_hold_v) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  // A release into an occupied, non-draining output is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_core_ferr;
      r_overrun   <= 1'b0;
      if (w_rel) begin
        if (w_out_free) begin
          r_data  <= r_hold;
          r_last  <= w_rel_last;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && m_axis.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
